// File: rtl/logu_pkg.sv
// Shared types and defaults for the bit-serial logic unit: opcodes, FSM states
// and the legal-opcode helper used by the issue logic.
package logu_pkg;

   localparam int unsigned LOGU_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_NOT = 3'b011,
      OP_SHL = 3'b100
   } logu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } logu_state_e;

   // Codes 101..111 are reserved; they still run the full bit loop but yield zero.
   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= 3'(OP_SHL));
   endfunction

endpackage

// File: rtl/logu_bit_slice.sv
// One-bit logic slice shared by both requesters. The carry path only matters
// for SHL, where it forwards the previous operand bit into the current position.
module logu_bit_slice
   import logu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   input  logic [2:0] op_i,
   output logic       out_o,
   output logic       cout_o
);

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      out_o  = 1'b0;
      cout_o = 1'b0;
      case (op_i)
         OP_AND:  out_o = a_i & b_i;
         OP_OR:   out_o = a_i | b_i;
         OP_XOR:  out_o = a_i ^ b_i;
         OP_NOT:  out_o = ~a_i;
         OP_SHL: begin
            out_o  = cin_i;
            cout_o = a_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/logu_seq.sv
// Two-requester bit-serial logic unit: round-robin issue, one result bit per
// cycle LSB first, result held until the consumer takes it.
module logu_seq
   import logu_pkg::*;
#(
   parameter int unsigned WIDTH = LOGU_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             rsp_err
);

   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logu_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             id_q, id_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             grant_id;
   logic             accept;
   logic [2:0]       op_sel;
   logic             slice_out;
   logic             slice_cout;

   // On contention the requester not served last wins; a lone requester always wins.
   assign grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
   assign accept     = rst_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant_id;
   assign req1_ready = accept && grant_id;
   assign op_sel     = grant_id ? req1_op : req0_op;

   logu_bit_slice u_slice (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .cin_i  (carry_q),
      .op_i   (op_q),
      .out_o  (slice_out),
      .cout_o (slice_cout)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         last_q   <= 1'b1;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         id_q     <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         last_q   <= last_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         id_q     <= id_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      last_d   = last_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      id_d     = id_q;
      err_d    = err_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               carry_d = 1'b0;
               last_d  = grant_id;
               id_d    = grant_id;
               a_d     = grant_id ? req1_a : req0_a;
               b_d     = grant_id ? req1_b : req0_b;
               op_d    = op_sel;
               err_d   = !op_is_legal(op_sel);
            end
         end
         ST_RUN: begin
            // Operands shift right so the slice always sees the current bit at position 0.
            result_d = {slice_out, result_q[WIDTH-1:1]};
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            carry_d  = slice_cout;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_data  = result_q;
   assign rsp_id    = id_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_logu_seq.sv
// Directed bench for logu_seq: a vector table of single operations plus
// hand-written arbitration, back-pressure and mid-operation reset sequences.
module tb_logu_seq;
   import logu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]   req0_op, req1_op;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_id, rsp_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic         id;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_data;
      logic         exp_err;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   logu_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .rsp_err    (rsp_err)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_req(input logic id, input logic v, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      if (id) begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   // Called at a negedge with the request already driven; returns at the negedge after the accept edge.
   task automatic accept_held(input logic id, input string nm);
      #1;
      check({nm, " ready"}, id ? req1_ready : req0_ready, 1);
      @(posedge clk);
      @(negedge clk);
      drive_req(id, 1'b0, 3'b111, 8'h3C, 8'hC3);
   endtask

   task automatic accept_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input string nm);
      drive_req(id, 1'b1, op, a, b);
      accept_held(id, nm);
   endtask

   task automatic wait_rsp(input logic [W-1:0] ed, input logic eid, input logic eerr,
                           input string nm, input logic handshake);
      int   lat;
      logic saw_ready;
      lat       = 0;
      saw_ready = 1'b0;
      while (!rsp_valid && lat < W + 4) begin
         @(negedge clk);
         lat++;
         saw_ready |= req0_ready | req1_ready;
      end
      check({nm, " latency"}, lat, W);
      check({nm, " readies busy"}, saw_ready, 0);
      check({nm, " data"}, rsp_data, ed);
      check({nm, " id/err"}, {rsp_id, rsp_err}, {eid, eerr});
      if (handshake) begin
         @(negedge clk);
         check({nm, " valid after hs"}, rsp_valid, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   quiet_cnt;
      logic saw_valid;

      vecs[0] = '{1'b0, 3'(OP_AND), 8'hC3, 8'h5A, 8'h42, 1'b0};
      vecs[1] = '{1'b1, 3'(OP_SHL), 8'h81, 8'h00, 8'h02, 1'b0};
      vecs[2] = '{1'b1, 3'(OP_NOT), 8'hA5, 8'hFF, 8'h5A, 1'b0};
      vecs[3] = '{1'b0, 3'b110,     8'hFF, 8'hFF, 8'h00, 1'b1};
      vecs[4] = '{1'b0, 3'(OP_OR),  8'h0F, 8'h30, 8'h3F, 1'b0};
      vecs[5] = '{1'b1, 3'(OP_XOR), 8'hF0, 8'hFF, 8'h0F, 1'b0};
      vecs[6] = '{1'b0, 3'(OP_SHL), 8'hFF, 8'h00, 8'hFE, 1'b0};
      vecs[7] = '{1'b1, 3'b111,     8'hAA, 8'h55, 8'h00, 1'b1};
      vecs[8] = '{1'b1, 3'(OP_AND), 8'hFF, 8'hAA, 8'hAA, 1'b0};

      drive_req(1'b0, 1'b1, 3'(OP_AND), 8'hFF, 8'hFF);
      drive_req(1'b1, 1'b0, 3'(OP_AND), 8'h00, 8'h00);
      rsp_ready = 1'b1;

      // Reset state, with a request already pending.
      repeat (2) @(negedge clk);
      #1;
      check("reset outputs", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
      check("reset ready0", req0_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);

      // Contention: req0 first after reset, req1 held and served next.
      drive_req(1'b0, 1'b1, 3'(OP_XOR), 8'hF0, 8'hFF);
      drive_req(1'b1, 1'b1, 3'(OP_OR),  8'h0F, 8'h30);
      #1;
      check("cont1 ready1 low", req1_ready, 0);
      accept_held(1'b0, "cont1 req0");
      wait_rsp(8'h0F, 1'b0, 1'b0, "cont1 req0", 1'b1);
      accept_held(1'b1, "cont1 req1");
      wait_rsp(8'h3F, 1'b1, 1'b0, "cont1 req1", 1'b1);

      // Next contention goes back to req0.
      drive_req(1'b0, 1'b1, 3'(OP_AND), 8'hFF, 8'h0F);
      drive_req(1'b1, 1'b1, 3'(OP_AND), 8'hFF, 8'hF0);
      #1;
      check("cont2 ready1 low", req1_ready, 0);
      accept_held(1'b0, "cont2 req0");
      wait_rsp(8'h0F, 1'b0, 1'b0, "cont2 req0", 1'b1);
      accept_held(1'b1, "cont2 req1");
      wait_rsp(8'hF0, 1'b1, 1'b0, "cont2 req1", 1'b1);

      for (int i = 0; i < 9; i++) begin
         accept_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
         wait_rsp(vecs[i].exp_data, vecs[i].id, vecs[i].exp_err, $sformatf("vec%0d", i), 1'b1);
      end

      // Back-pressure: result held for 5 cycles while req1 waits.
      rsp_ready = 1'b0;
      accept_op(1'b0, 3'(OP_XOR), 8'hAA, 8'h0F, "hold");
      wait_rsp(8'hA5, 1'b0, 1'b0, "hold", 1'b0);
      drive_req(1'b1, 1'b1, 3'(OP_AND), 8'hFF, 8'hFF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d valid", k), rsp_valid, 1);
         check($sformatf("hold%0d outputs", k), {rsp_id, rsp_err, rsp_data}, {2'b00, 8'hA5});
         check($sformatf("hold%0d readies", k), {req0_ready, req1_ready}, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("post-hs valid", rsp_valid, 0);
      check("post-hs idle ready1", req1_ready, 1);
      // Dropping the request before any edge must leave the unit idle.
      drive_req(1'b1, 1'b0, 3'(OP_AND), 8'hFF, 8'hFF);
      #1;
      check("dropped readies", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      check("dropped no rsp", rsp_valid, 0);

      // Reset at bit 4 of RUN: req0 in flight would favour req1 without reset.
      accept_op(1'b0, 3'(OP_OR), 8'hFF, 8'h00, "rst op");
      repeat (4) @(negedge clk);
      drive_req(1'b1, 1'b1, 3'(OP_AND), 8'hFF, 8'hFF);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrun reset outputs", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
      check("midrun reset readies", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_req(1'b1, 1'b0, 3'(OP_AND), 8'h00, 8'h00);
      saw_valid = 1'b0;
      for (quiet_cnt = 0; quiet_cnt < W + 4; quiet_cnt++) begin
         @(negedge clk);
         saw_valid |= rsp_valid;
      end
      check("abandoned no rsp", saw_valid, 0);

      drive_req(1'b0, 1'b1, 3'(OP_AND), 8'hC3, 8'h5A);
      drive_req(1'b1, 1'b1, 3'(OP_NOT), 8'hA5, 8'h00);
      #1;
      check("post-rst ready1 low", req1_ready, 0);
      accept_held(1'b0, "post-rst req0");
      wait_rsp(8'h42, 1'b0, 1'b0, "post-rst req0", 1'b1);
      accept_held(1'b1, "post-rst req1");
      wait_rsp(8'h5A, 1'b1, 1'b0, "post-rst req1", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
